// File: rtl/neuron_backward_pkg.sv
// rtl/neuron_backward_pkg.sv - shared lane geometry and saturation helper for the ReLU neuron stages
package neuron_backward_pkg;

   localparam int NB_NC    = 4;
   localparam int NB_WD    = 4;
   localparam int NB_WE    = 8;
   localparam int NB_DEPTH = 8;

   // Clipped-ReLU saturation level for a WD-bit activation lane.
   function automatic int max_yc(input int wd);
      return (1 << (wd - 1)) - 1;
   endfunction

endpackage

// File: rtl/neuron_backward_mask_fifo.sv
// rtl/neuron_backward_mask_fifo.sv - derivative mask FIFO, synchronous write and combinational read at rptr
module neuron_backward_mask_fifo
   import neuron_backward_pkg::*;
#(
   parameter int NC    = NB_NC,
   parameter int DEPTH = NB_DEPTH,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic [NC-1:0] i_wdata,
   input  logic          i_pop,
   output logic [NC-1:0] o_rdata,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   logic [NC-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   // Storage needs no reset: the pointers and count alone define what is valid.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (i_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/neuron_backward.sv
// rtl/neuron_backward.sv - ReLU backward stage: masks stored from forward activations gate incoming errors
module neuron_backward
   import neuron_backward_pkg::*;
#(
   parameter int NC    = NB_NC,
   parameter int WD    = NB_WD,
   parameter int WE    = NB_WE,
   parameter int DEPTH = NB_DEPTH
) (
   input  logic                         iCLK,
   input  logic                         iRST_N,
   input  logic                         iValid_AF,
   output logic                         oReady_AF,
   input  logic [NC*WD-1:0]             iData_AF,
   input  logic                         iValid_BE,
   output logic                         oReady_BE,
   input  logic [NC*WE-1:0]             iData_BE,
   output logic                         oValid_AE,
   input  logic                         iReady_AE,
   output logic [NC*WE-1:0]             oData_AE,
   output logic [$clog2(DEPTH+1)-1:0]   oCount
);

   localparam int            CW       = $clog2(DEPTH + 1);
   localparam logic [WD-1:0] MAX_YC_V = WD'(max_yc(WD));

   logic [NC-1:0]    w_mask_wr;
   logic [NC-1:0]    w_mask_rd;
   logic [NC*WE-1:0] w_delta;
   logic [CW-1:0]    w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_fire;
   logic             w_rdy;
   logic             r_valid;
   logic [NC*WE-1:0] r_data;

   // Derivative of the clipped ReLU is 1 only strictly inside the linear region.
   always_comb begin
      w_mask_wr = '0;
      for (int i = 0; i < NC; i++) begin
         w_mask_wr[i] = (iData_AF[i*WD +: WD] != '0) && (iData_AF[i*WD +: WD] < MAX_YC_V);
      end
   end

   always_comb begin
      w_delta = '0;
      for (int i = 0; i < NC; i++) begin
         w_delta[i*WE +: WE] = w_mask_rd[i] ? iData_BE[i*WE +: WE] : '0;
      end
   end

   assign w_rdy     = r_valid ? iReady_AE : 1'b1;
   assign oReady_AF = !w_full;
   assign oReady_BE = !w_empty && w_rdy;
   assign w_push    = iValid_AF && !w_full;
   assign w_fire    = iValid_BE && oReady_BE;

   neuron_backward_mask_fifo #(
      .NC    (NC),
      .DEPTH (DEPTH)
   ) u_mask_fifo (
      .i_clk   (iCLK),
      .i_rst_n (iRST_N),
      .i_push  (w_push),
      .i_wdata (w_mask_wr),
      .i_pop   (w_fire),
      .o_rdata (w_mask_rd),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_fire) begin
         r_valid <= 1'b1;
         r_data  <= w_delta;
      end else if (r_valid && iReady_AE) begin
         r_valid <= 1'b0;
      end
   end

   assign oValid_AE = r_valid;
   assign oData_AE  = r_data;
   assign oCount    = w_count;

endmodule

// File: tb/tb_neuron_backward.sv
// tb/tb_neuron_backward.sv - scoreboard bench for neuron_backward
module tb_neuron_backward;

   localparam int NC    = 4;
   localparam int WD    = 4;
   localparam int WE    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic             clk = 1'b0;
   logic             iRST_N;
   logic             iValid_AF;
   logic             oReady_AF;
   logic [NC*WD-1:0] iData_AF;
   logic             iValid_BE;
   logic             oReady_BE;
   logic [NC*WE-1:0] iData_BE;
   logic             oValid_AE;
   logic             iReady_AE;
   logic [NC*WE-1:0] oData_AE;
   logic [CW-1:0]    oCount;

   always #5 clk = ~clk;

   neuron_backward #(.NC(NC), .WD(WD), .WE(WE), .DEPTH(DEPTH)) dut (
      .iCLK      (clk),
      .iRST_N    (iRST_N),
      .iValid_AF (iValid_AF),
      .oReady_AF (oReady_AF),
      .iData_AF  (iData_AF),
      .iValid_BE (iValid_BE),
      .oReady_BE (oReady_BE),
      .iData_BE  (iData_BE),
      .oValid_AE (oValid_AE),
      .iReady_AE (iReady_AE),
      .oData_AE  (oData_AE),
      .oCount    (oCount)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [NC-1:0]    mq[$];
   logic [NC*WE-1:0] exp_q[$];
   logic [NC*WD-1:0] act_src[$];
   logic [NC*WE-1:0] err_src[$];
   bit               m_valid = 1'b0;
   logic             rdy_ae  = 1'b1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NC-1:0] mask_of(input logic [NC*WD-1:0] a);
      logic [NC-1:0] m;
      logic [WD-1:0] v;
      for (int i = 0; i < NC; i++) begin
         v    = a[i*WD +: WD];
         m[i] = (v > 0) && (v < 7);
      end
      return m;
   endfunction

   function automatic logic [NC*WE-1:0] gate(input logic [NC-1:0] m, input logic [NC*WE-1:0] e);
      logic [NC*WE-1:0] d;
      for (int i = 0; i < NC; i++) begin
         d[i*WE +: WE] = m[i] ? e[i*WE +: WE] : 8'h00;
      end
      return d;
   endfunction

   // One clock: drive at negedge, check before posedge, advance the model at posedge.
   task automatic step();
      bit rdy_af, w_rdy, rdy_be, fire;
      logic [NC-1:0] m;
      iValid_AF = (act_src.size() != 0);
      iData_AF  = iValid_AF ? act_src[0] : '0;
      iValid_BE = (err_src.size() != 0);
      iData_BE  = iValid_BE ? err_src[0] : '0;
      iReady_AE = rdy_ae;
      #1;
      rdy_af = (mq.size() != DEPTH);
      w_rdy  = m_valid ? iReady_AE : 1'b1;
      rdy_be = (mq.size() != 0) && w_rdy;
      check("ready_af", 64'(oReady_AF), 64'(rdy_af));
      check("ready_be", 64'(oReady_BE), 64'(rdy_be));
      check("count", 64'(oCount), 64'(mq.size()));
      check("valid", 64'(oValid_AE), 64'(m_valid));
      if (m_valid) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 64'(exp_q.size()), 64'd1);
         end else begin
            check("delta", 64'(oData_AE), 64'(exp_q[0]));
            if (iReady_AE) void'(exp_q.pop_front());
         end
      end
      @(posedge clk);
      if (!iRST_N) begin
         mq.delete();
         exp_q.delete();
         act_src.delete();
         err_src.delete();
         m_valid = 1'b0;
      end else begin
         fire = iValid_BE && rdy_be;
         if (fire) begin
            m = mq.pop_front();
            exp_q.push_back(gate(m, iData_BE));
            void'(err_src.pop_front());
            m_valid = 1'b1;
         end else if (m_valid && iReady_AE) begin
            m_valid = 1'b0;
         end
         if (iValid_AF && rdy_af) begin
            mq.push_back(mask_of(iData_AF));
            void'(act_src.pop_front());
         end
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while ((act_src.size() != 0 || err_src.size() != 0 || m_valid) && k < budget) begin
         step();
         k++;
      end
      check("drain_done", 64'(act_src.size() + err_src.size() + int'(m_valid)), 64'd0);
   endtask

   function automatic logic [NC*WD-1:0] rand_act();
      logic [NC*WD-1:0] a;
      for (int i = 0; i < NC; i++) a[i*WD +: WD] = WD'($urandom_range(0, 7));
      return a;
   endfunction

   initial begin
      iRST_N = 1'b0;
      iValid_AF = 1'b0; iData_AF = '0;
      iValid_BE = 1'b0; iData_BE = '0;
      iReady_AE = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      iRST_N = 1'b1;
      #1;
      check("rst_count", 64'(oCount), 64'd0);
      check("rst_valid", 64'(oValid_AE), 64'd0);
      check("rst_data", 64'(oData_AE), 64'd0);
      check("rst_ready_af", 64'(oReady_AF), 64'd1);
      check("rst_ready_be", 64'(oReady_BE), 64'd0);

      // Single pair: lanes {0,3,7,5} with errors {10,-4,20,-1}
      act_src.push_back(16'h5730);
      err_src.push_back(32'hff14fc0a);
      run(2);
      #1;
      check("pair_valid", 64'(oValid_AE), 64'd1);
      check("pair_data", 64'(oData_AE), 64'hff00fc00);
      drain(10);

      // Fill to full, then one pop
      for (int i = 0; i < DEPTH; i++) act_src.push_back(rand_act());
      run(10);
      #1;
      check("fill_count", 64'(oCount), 64'd8);
      check("fill_ready_af", 64'(oReady_AF), 64'd0);
      err_src.push_back(32'($urandom));
      step();
      #1;
      check("pop_count", 64'(oCount), 64'd7);
      check("pop_ready_af", 64'(oReady_AF), 64'd1);
      for (int i = 0; i < DEPTH - 1; i++) err_src.push_back(32'($urandom));
      drain(20);

      // Error waiting on an empty FIFO
      err_src.push_back(32'($urandom));
      run(3);
      act_src.push_back(rand_act());
      drain(10);

      // Streaming with a pointer wrap
      for (int i = 0; i < 20; i++) begin
         act_src.push_back(rand_act());
         err_src.push_back(32'($urandom));
      end
      drain(40);

      // Downstream backpressure
      for (int i = 0; i < 4; i++) begin
         act_src.push_back(rand_act());
         err_src.push_back(32'($urandom));
      end
      rdy_ae = 1'b0;
      run(7);
      rdy_ae = 1'b1;
      drain(20);

      // Reset mid-operation with 5 stored masks and a pending delta
      for (int i = 0; i < 6; i++) act_src.push_back(rand_act());
      err_src.push_back(32'($urandom));
      rdy_ae = 1'b0;
      run(8);
      #1;
      check("pre_rst_count", 64'(oCount), 64'd5);
      check("pre_rst_valid", 64'(oValid_AE), 64'd1);
      iRST_N = 1'b0;
      step();
      iRST_N = 1'b1;
      rdy_ae = 1'b1;
      #1;
      check("mid_rst_count", 64'(oCount), 64'd0);
      check("mid_rst_valid", 64'(oValid_AE), 64'd0);
      check("mid_rst_ready_af", 64'(oReady_AF), 64'd1);
      check("mid_rst_ready_be", 64'(oReady_BE), 64'd0);
      for (int i = 0; i < 3; i++) begin
         act_src.push_back(rand_act());
         err_src.push_back(32'($urandom));
      end
      drain(20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
